// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared types and constants for the clock/alarm blocks
package clock_pkg;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZE, LOCKOUT} ring_state_e;

  localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/alarm_ring_ctrl.sv
// rtl/alarm_ring_ctrl.sv - turns the alarm match level into a ringing session with snooze, stop and timeout
module alarm_ring_ctrl
  import clock_pkg::*;
#(
  parameter int RING_TIMEOUT_S = SEC_PER_MIN,
  parameter int SNOOZE_S       = 300,
  parameter int MAX_SNOOZES    = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             tick_1hz,
  input  logic                             alarm_enable,
  input  logic                             alarm_trigger,
  input  logic                             snooze_btn,
  input  logic                             stop_btn,
  output logic                             buzzer,
  output logic                             ringing,
  output logic                             snoozing,
  output logic [$clog2(MAX_SNOOZES+1)-1:0] snooze_count
);

  localparam int CNT_MAX = (RING_TIMEOUT_S > SNOOZE_S) ? RING_TIMEOUT_S : SNOOZE_S;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int SC_W    = $clog2(MAX_SNOOZES + 1);

  localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_TIMEOUT_S - 1);
  localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_S - 1);
  localparam logic [SC_W-1:0]  SC_MAX      = SC_W'(MAX_SNOOZES);

  ring_state_e      state, state_d;
  logic [CNT_W-1:0] sec_cnt;
  logic             trig_q;
  logic             beep_phase;
  logic             take_snooze;
  logic             rise;

  // alarm_enable gates the trigger so an unloaded (X) comparator cannot start a session
  assign rise = alarm_enable & alarm_trigger & ~trig_q;

  always_comb begin
    state_d     = state;
    take_snooze = 1'b0;
    case (state)
      IDLE: begin
        if (rise) state_d = RINGING;
      end
      RINGING: begin
        if (!alarm_enable)                          state_d = IDLE;
        else if (stop_btn)                          state_d = LOCKOUT;
        else if (tick_1hz && sec_cnt == RING_LAST)  state_d = LOCKOUT;
        else if (snooze_btn && snooze_count < SC_MAX) begin
          state_d     = SNOOZE;
          take_snooze = 1'b1;
        end
      end
      SNOOZE: begin
        if (!alarm_enable)                           state_d = IDLE;
        else if (stop_btn)                           state_d = LOCKOUT;
        else if (tick_1hz && sec_cnt == SNOOZE_LAST) state_d = RINGING;
      end
      LOCKOUT: begin
        if (!alarm_enable || !alarm_trigger) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      trig_q       <= 1'b1;
      sec_cnt      <= '0;
      beep_phase   <= 1'b0;
      snooze_count <= '0;
    end else begin
      state  <= state_d;
      trig_q <= alarm_trigger;

      // Entering any state restarts the shared seconds count; the entry-cycle tick is dropped
      if (state_d != state)
        sec_cnt <= '0;
      else if (tick_1hz && (state == RINGING || state == SNOOZE))
        sec_cnt <= sec_cnt + CNT_W'(1);

      if (state_d == RINGING && state != RINGING)
        beep_phase <= 1'b1;
      else if (state == RINGING && tick_1hz)
        beep_phase <= ~beep_phase;

      if (state_d == IDLE || state == IDLE)
        snooze_count <= '0;
      else if (take_snooze && snooze_count != SC_MAX)
        snooze_count <= snooze_count + SC_W'(1);
    end
  end

  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);
  assign buzzer   = ringing & beep_phase;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// tb/tb_alarm_ring_ctrl.sv - scoreboard bench for alarm_ring_ctrl with short timeouts
module tb_alarm_ring_ctrl;

  localparam int RT = 4;
  localparam int SN = 3;
  localparam int MS = 2;

  localparam int M_IDLE = 0;
  localparam int M_RING = 1;
  localparam int M_SNZ  = 2;
  localparam int M_LOCK = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       alarm_enable = 1'b0;
  logic       alarm_trigger = 1'bx;
  logic       snooze_btn = 1'b0;
  logic       stop_btn = 1'b0;
  logic       buzzer, ringing, snoozing;
  logic [1:0] snooze_count;

  typedef struct {
    logic       r;
    logic       s;
    logic       b;
    logic [1:0] c;
  } exp_t;

  exp_t  sb[$];
  int    checks = 0;
  int    passes = 0;
  string cur_test = "reset";

  int         m_state = M_IDLE;
  int         m_left  = 0;
  logic       m_phase = 1'b0;
  logic [1:0] m_count = 2'd0;
  logic       m_trig_q = 1'b1;

  alarm_ring_ctrl #(
    .RING_TIMEOUT_S(RT),
    .SNOOZE_S      (SN),
    .MAX_SNOOZES   (MS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .alarm_enable (alarm_enable),
    .alarm_trigger(alarm_trigger),
    .snooze_btn   (snooze_btn),
    .stop_btn     (stop_btn),
    .buzzer       (buzzer),
    .ringing      (ringing),
    .snoozing     (snoozing),
    .snooze_count (snooze_count)
  );

  always #5 clk = ~clk;

  // Reference model: counts seconds remaining downwards, evaluated once per clock with current inputs
  task automatic model_step();
    int   nxt;
    logic rise;
    exp_t e;
    if (rst !== 1'b1) begin
      m_state = M_IDLE; m_count = 2'd0; m_phase = 1'b0; m_left = 0; m_trig_q = 1'b1;
    end else begin
      rise = alarm_trigger & ~m_trig_q;
      nxt  = m_state;
      case (m_state)
        M_IDLE: if (alarm_enable === 1'b1 && rise === 1'b1) begin
          nxt = M_RING; m_count = 2'd0; m_phase = 1'b1; m_left = RT;
        end
        M_RING: begin
          if (!alarm_enable) begin nxt = M_IDLE; m_count = 2'd0; end
          else if (stop_btn) nxt = M_LOCK;
          else if (tick_1hz && m_left == 1) nxt = M_LOCK;
          else if (snooze_btn && m_count < MS) begin
            nxt = M_SNZ; m_count = m_count + 2'd1; m_left = SN;
          end else if (tick_1hz) begin
            m_left = m_left - 1; m_phase = ~m_phase;
          end
        end
        M_SNZ: begin
          if (!alarm_enable) begin nxt = M_IDLE; m_count = 2'd0; end
          else if (stop_btn) nxt = M_LOCK;
          else if (tick_1hz && m_left == 1) begin
            nxt = M_RING; m_phase = 1'b1; m_left = RT;
          end else if (tick_1hz) m_left = m_left - 1;
        end
        default: if (!alarm_enable || alarm_trigger === 1'b0) begin
          nxt = M_IDLE; m_count = 2'd0;
        end
      endcase
      m_state  = nxt;
      m_trig_q = alarm_trigger;
    end
    e.r = (m_state == M_RING);
    e.s = (m_state == M_SNZ);
    e.b = e.r & m_phase;
    e.c = m_count;
    sb.push_back(e);
  endtask

  // One clock: compare the result of the previous clock, then apply new stimulus
  task automatic drive(input logic t, input logic s, input logic st);
    exp_t e;
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (ringing !== e.r || snoozing !== e.s || buzzer !== e.b || snooze_count !== e.c)
        $display("FAIL %s t=%0t: ring/snz/buzz/cnt got %b/%b/%b/%0d expected %b/%b/%b/%0d",
                 cur_test, $time, ringing, snoozing, buzzer, snooze_count, e.r, e.s, e.b, e.c);
      else
        passes++;
    end
    tick_1hz = t; snooze_btn = s; stop_btn = st;
    model_step();
    @(posedge clk);
    #1;
    tick_1hz = 1'b0; snooze_btn = 1'b0; stop_btn = 1'b0;
  endtask

  task automatic secs(input int n);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 9; j++) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic fresh_trigger();
    alarm_trigger = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    alarm_trigger = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    cur_test = "reset";
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if ({ringing, snoozing, buzzer, snooze_count} !== 5'b0)
      $display("FAIL reset_outputs got %b expected 00000", {ringing, snoozing, buzzer, snooze_count});
    else passes++;
  endtask

  task automatic test_ring_timeout();
    cur_test = "ring_timeout";
    alarm_enable = 1'b1;
    fresh_trigger();
    checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1)
      $display("FAIL ring_start got ring=%b buzz=%b expected 1/1", ringing, buzzer);
    else passes++;
    secs(3);
    checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b0)
      $display("FAIL ring_after_3_ticks got ring=%b buzz=%b expected 1/0", ringing, buzzer);
    else passes++;
    secs(1);
    checks++;
    if (ringing !== 1'b0) $display("FAIL ring_timeout got %b expected 0", ringing);
    else passes++;
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (ringing !== 1'b0) $display("FAIL lockout_no_rering got %b expected 0", ringing);
    else passes++;
    alarm_trigger = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1);
    checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0)
      $display("FAIL idle_buttons got ring=%b snz=%b expected 0/0", ringing, snoozing);
    else passes++;
  endtask

  task automatic test_snooze();
    cur_test = "snooze";
    fresh_trigger();
    secs(1);
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (snoozing !== 1'b1 || snooze_count !== 2'd1 || buzzer !== 1'b0)
      $display("FAIL snooze_enter got snz=%b cnt=%0d buzz=%b expected 1/1/0", snoozing, snooze_count, buzzer);
    else passes++;
    secs(2);
    checks++;
    if (snoozing !== 1'b1) $display("FAIL snooze_hold got %b expected 1", snoozing);
    else passes++;
    secs(1);
    checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1)
      $display("FAIL snooze_rering got ring=%b buzz=%b expected 1/1", ringing, buzzer);
    else passes++;
    drive(1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_snooze_limit();
    cur_test = "snooze_limit";
    fresh_trigger();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b0);
      secs(3);
    end
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (ringing !== 1'b1 || snoozing !== 1'b0 || snooze_count !== 2'd2)
      $display("FAIL snooze_limit got ring=%b snz=%b cnt=%0d expected 1/0/2", ringing, snoozing, snooze_count);
    else passes++;
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (ringing !== 1'b0) $display("FAIL stop_after_limit got %b expected 0", ringing);
    else passes++;
  endtask

  task automatic test_back_to_back();
    cur_test = "stop_and_snooze";
    fresh_trigger();
    drive(1'b0, 1'b1, 1'b0);
    secs(3);
    drive(1'b0, 1'b1, 1'b1);
    checks++;
    if (ringing !== 1'b0 || snoozing !== 1'b0 || snooze_count !== 2'd1)
      $display("FAIL stop_wins got ring=%b snz=%b cnt=%0d expected 0/0/1", ringing, snoozing, snooze_count);
    else passes++;
    fresh_trigger();
    checks++;
    if (ringing !== 1'b1 || snooze_count !== 2'd0)
      $display("FAIL rering_fresh got ring=%b cnt=%0d expected 1/0", ringing, snooze_count);
    else passes++;
  endtask

  task automatic test_disable_snooze();
    cur_test = "disable_in_snooze";
    drive(1'b0, 1'b1, 1'b0);
    alarm_enable = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (snoozing !== 1'b0 || buzzer !== 1'b0 || snooze_count !== 2'd0)
      $display("FAIL disable_snooze got snz=%b buzz=%b cnt=%0d expected 0/0/0", snoozing, buzzer, snooze_count);
    else passes++;
    alarm_enable = 1'b1;
    secs(5);
    checks++;
    if (ringing !== 1'b0) $display("FAIL disable_no_rering got %b expected 0", ringing);
    else passes++;
  endtask

  task automatic test_async_reset();
    cur_test = "async_reset";
    fresh_trigger();
    secs(1);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({ringing, snoozing, buzzer, snooze_count} !== 5'b0)
      $display("FAIL async_reset got %b expected 00000", {ringing, snoozing, buzzer, snooze_count});
    else passes++;
    sb.delete();
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    secs(2);
    checks++;
    if (ringing !== 1'b0) $display("FAIL no_ring_after_reset got %b expected 0", ringing);
    else passes++;
    fresh_trigger();
    checks++;
    if (ringing !== 1'b1 || buzzer !== 1'b1)
      $display("FAIL ring_after_reset got ring=%b buzz=%b expected 1/1", ringing, buzzer);
    else passes++;
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_ring_timeout();
    test_snooze();
    test_snooze_limit();
    test_back_to_back();
    test_disable_snooze();
    test_async_reset();
    checks++;
    if (sb.size() !== 1) $display("FAIL scoreboard_drain got %0d entries expected 1", sb.size());
    else passes++;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
